// File: rtl/sc_mmio_responder.sv
// MMIO responder for the single-cycle CPU data bus:
// output/input ports, compare timer and a FIFO-fed 8N1 transmitter.
module sc_mmio_responder #(
  parameter logic [31:0] BASE         = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 50,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  input  logic [31:0] in_port,
  output logic [31:0] out_port,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic sel;
  logic wr;
  logic hit_out;
  logic hit_in;
  logic hit_tcnt;
  logic hit_tcmp;
  logic hit_stat;
  logic hit_txd;

  assign sel      = addr[31:8] == BASE[31:8];
  assign wr       = we & sel;
  assign hit_out  = sel && addr[7:2] == 6'h00;
  assign hit_in   = sel && addr[7:2] == 6'h01;
  assign hit_tcnt = sel && addr[7:2] == 6'h02;
  assign hit_tcmp = sel && addr[7:2] == 6'h03;
  assign hit_stat = sel && addr[7:2] == 6'h04;
  assign hit_txd  = sel && addr[7:2] == 6'h05;

  logic unused;
  assign unused = ^addr[1:0];

  logic [31:0] out_q;
  logic [31:0] sync1;
  logic [31:0] sync2;
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic        tflag;
  logic        ovf;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bitn;
  logic [2:0]    bit_n;
  logic [7:0]    shreg;
  logic [7:0]    sh_n;
  logic          tx_q;
  logic          tx_n;
  logic          busy;

  logic match;
  logic clr;

  assign empty    = count == '0;
  assign full     = count == DEPTH;
  assign busy     = state != IDLE;
  assign push_req = wr & hit_txd;
  assign push_ok  = push_req & (~full | pop);
  assign match    = ~(wr & hit_tcnt) & (tcnt == tcmp);
  assign clr      = wr & hit_stat;

  assign out_port = out_q;
  assign tx       = tx_q;
  assign irq      = tflag;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_out:  rdata = out_q;
      hit_in:   rdata = sync2;
      hit_tcnt: rdata = tcnt;
      hit_tcmp: rdata = tcmp;
      hit_stat: rdata = {27'b0, ovf, busy, empty, full, tflag};
      hit_txd:  rdata = '0;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
      sync1 <= '0;
      sync2 <= '0;
      tcnt  <= '0;
      tcmp  <= '1;
      tflag <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      if (wr && hit_out) out_q <= wdata;
      if (wr && hit_tcmp) tcmp <= wdata;
      if (wr && hit_tcnt) tcnt <= wdata;
      else if (match) tcnt <= '0;
      else tcnt <= tcnt + 32'd1;
      // set beats a simultaneous write-one-to-clear
      tflag <= match | (tflag & ~(clr & wdata[0]));
      ovf   <= (push_req & ~push_ok) | (ovf & ~(clr & wdata[4]));
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wp] <= wdata[7:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bit_n;
      shreg <= sh_n;
      tx_q  <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bitn;
    sh_n    = shreg;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
          cnt_n   = '0;
          sh_n    = mem[rp];
        end
      end
      START: begin
        if (cnt == CNT_MAX) begin
          state_n = DATA;
          cnt_n   = '0;
          bit_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_n = '0;
          sh_n  = {1'b0, shreg[7:1]};
          if (bitn == 3'd7) state_n = STOP;
          else bit_n = bitn + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_MAX) state_n = IDLE;
        else cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // line level follows the state being entered, so tx is a clean flop
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sc_mmio_responder.sv
// Bench for sc_mmio_responder: directed scenarios plus random bus
// traffic, checked every cycle against a queue-based reference model.
module tb_sc_mmio_responder;

  localparam int CPB = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] A_OUT  = BASE + 32'h00;
  localparam logic [31:0] A_IN   = BASE + 32'h04;
  localparam logic [31:0] A_TCNT = BASE + 32'h08;
  localparam logic [31:0] A_TCMP = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;
  localparam logic [31:0] A_TXD  = BASE + 32'h14;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic [31:0] in_port = '0;
  logic [31:0] out_port;
  logic        tx;
  logic        irq;

  always #5 clock = ~clock;

  sc_mmio_responder #(
    .BASE(BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(8)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .addr(addr),
    .wdata(wdata),
    .we(we),
    .rdata(rdata),
    .in_port(in_port),
    .out_port(out_port),
    .tx(tx),
    .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_out, m_s1, m_s2, m_tcnt, m_tcmp;
  logic        m_tflag, m_ovf, m_busy;
  int          m_k;
  logic [7:0]  m_byte;
  logic [7:0]  q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_out = '0; m_s1 = '0; m_s2 = '0;
    m_tcnt = '0; m_tcmp = '1;
    m_tflag = 1'b0; m_ovf = 1'b0;
    m_busy = 1'b0; m_k = 0; m_byte = '0;
    q.delete();
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (a[31:8] != BASE[31:8]) return '0;
    case (a[7:2])
      6'd0: return m_out;
      6'd1: return m_s2;
      6'd2: return m_tcnt;
      6'd3: return m_tcmp;
      6'd4: return {27'b0, m_ovf, m_busy, q.size() == 0,
                    q.size() == 8, m_tflag};
      default: return '0;
    endcase
  endfunction

  function automatic logic m_tx();
    if (!m_busy) return 1'b1;
    if (m_k < CPB) return 1'b0;
    if (m_k < 9 * CPB) return m_byte[(m_k - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic m_edge();
    logic wr, pop, push, acc, match, clr;
    logic [5:0] off;
    int n;
    if (!resetn) begin
      m_reset();
      return;
    end
    wr    = we && (addr[31:8] == BASE[31:8]);
    off   = addr[7:2];
    n     = q.size();
    pop   = !m_busy && n > 0;
    push  = wr && off == 6'd5;
    acc   = push && (n < 8 || pop);
    match = !(wr && off == 6'd2) && m_tcnt == m_tcmp;
    clr   = wr && off == 6'd4;
    if (wr && off == 6'd2) m_tcnt = wdata;
    else if (match) m_tcnt = '0;
    else m_tcnt = m_tcnt + 32'd1;
    if (wr && off == 6'd3) m_tcmp = wdata;
    if (wr && off == 6'd0) m_out = wdata;
    m_tflag = match || (m_tflag && !(clr && wdata[0]));
    m_ovf = (push && !acc) || (m_ovf && !(clr && wdata[4]));
    if (m_busy) begin
      m_k++;
      if (m_k == 10 * CPB) m_busy = 1'b0;
    end else if (pop) begin
      m_busy = 1'b1;
      m_k = 0;
      m_byte = q.pop_front();
    end
    if (acc) q.push_back(wdata[7:0]);
    m_s2 = m_s1;
    m_s1 = in_port;
  endtask

  task automatic tick();
    @(posedge clock);
    m_edge();
    @(negedge clock);
    chk("rdata", rdata, m_rd(addr));
    chk("tx", 32'(tx), 32'(m_tx()));
    chk("irq", 32'(irq), 32'(m_tflag));
    chk("out_port", out_port, m_out);
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d,
                     input logic w);
    addr = a;
    wdata = d;
    we = w;
    tick();
    we = 1'b0;
  endtask

  logic [9:0] seq;
  logic [31:0] ra, rd;

  initial begin
    m_reset();
    addr = A_STAT;
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("stat_reset", rdata, 32'h4);
    addr = A_TCMP;
    #1;
    chk("tcmp_reset", rdata, 32'hFFFF_FFFF);
    chk("tx_reset", 32'(tx), 32'h1);
    chk("out_reset", out_port, 32'h0);

    put(A_OUT, 32'hDEAD_BEEF, 1'b1);
    chk("out_wr", out_port, 32'hDEAD_BEEF);
    put(BASE - 32'd4, 32'h1234_5678, 1'b1);
    chk("out_outside", out_port, 32'hDEAD_BEEF);
    addr = A_OUT;
    #1;
    chk("out_rd", rdata, 32'hDEAD_BEEF);

    put(A_TCMP, 32'd5, 1'b1);
    put(A_TCNT, 32'd0, 1'b1);
    addr = A_TCNT;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("irq_early", 32'(irq), 32'h0);
    end
    tick();
    chk("irq_match", 32'(irq), 32'h1);
    chk("tcnt_wrap", rdata, 32'h0);
    put(A_STAT, 32'h1, 1'b1);
    chk("irq_clr", 32'(irq), 32'h0);
    repeat (4) tick();
    put(A_STAT, 32'h1, 1'b1);
    chk("irq_setwins", 32'(irq), 32'h1);

    put(A_TXD, 32'h0000_00A5, 1'b1);
    tick();
    addr = A_STAT;
    seq = 10'b1101001010;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        #1;
        chk("a5_bit", 32'(tx), 32'(seq[i]));
        chk("a5_busy", 32'(rdata[3]), 32'h1);
        tick();
      end
    end
    chk("a5_empty", 32'(rdata[2]), 32'h1);
    chk("a5_idle", 32'(rdata[3]), 32'h0);

    for (int i = 0; i < 10; i++) put(A_TXD, 32'h10 + i, 1'b1);
    addr = A_STAT;
    #1;
    chk("burst_full", 32'(rdata[1]), 32'h1);
    chk("burst_ovf", 32'(rdata[4]), 32'h1);
    repeat (9 * (10 * CPB + 1) + 10) tick();
    put(A_STAT, 32'h10, 1'b1);

    put(A_TXD, 32'h3C, 1'b1);
    repeat (CPB * 4) tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("tx_async_rst", 32'(tx), 32'h1);
    m_reset();
    tick();
    tick();
    resetn = 1'b1;
    addr = A_STAT;
    #1;
    chk("stat_after_rst", rdata, 32'h4);
    in_port = 32'h1234_5678;
    addr = A_IN;
    tick();
    chk("in0_edge1", rdata, 32'h0);
    tick();
    chk("in0_edge2", rdata, 32'h1234_5678);

    repeat (3000) begin
      case ($urandom_range(0, 9))
        0: ra = A_OUT;
        1: ra = A_IN;
        2: ra = A_TCNT;
        3: ra = A_TCMP;
        4: ra = A_STAT;
        5, 6: ra = A_TXD;
        7: ra = BASE + {22'b0, 6'($urandom_range(6, 63)), 2'b00};
        8: ra = BASE - 32'($urandom_range(1, 100)) * 32'd4;
        default: ra = BASE + 32'($urandom_range(0, 255));
      endcase
      if (ra == A_TCNT || ra == A_TCMP) begin
        if ($urandom_range(0, 3) == 0)
          rd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else
          rd = 32'($urandom_range(0, 40));
      end else begin
        rd = $urandom;
      end
      if ($urandom_range(0, 7) == 0) in_port = $urandom;
      put(ra, rd, $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
